// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one uart_tx; valid->ready 1 clk, ready->tx_start 1 clk;
// sources stall on req_ready, tx paced by tx_done_tick, gap timeout aborts. UART_TX_ARB_CHKSUM_EN adds checksum byte.
module uart_tx_arbiter #(
   parameter int          N_REQ       = 4,
   parameter logic [15:0] GAP_TIMEOUT = 16'd50000,
   localparam int         GW          = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic               tx_start,
   output logic [7:0]         tx_din,
   input  logic               tx_done_tick,
   output logic               busy,
   output logic [GW-1:0]      grant_id,
   output logic               pkt_done,
   output logic               err_abort
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT
`ifdef UART_TX_ARB_CHKSUM_EN
      ,
      S_CHK,
      S_WAIT_CHK
`endif
   } state_t;

   localparam logic [GW:0]   NREQ_W  = (GW+1)'(N_REQ);
   localparam logic [GW-1:0] RR_INIT = GW'(N_REQ - 1);

   state_t          state, state_n;
   logic [7:0]      tx_din_n;
   logic            last_f, last_n;
   logic [GW-1:0]   grant_n;
   logic [GW-1:0]   rr_ptr, rr_n;
   logic [15:0]     gap_cnt, gap_n;
   logic            start_n, done_n, abort_n;
   logic [7:0]      src_byte [N_REQ];
   logic            arb_hit;
   logic [GW-1:0]   arb_id;
   logic [GW:0]     arb_idx;
`ifdef UART_TX_ARB_CHKSUM_EN
   logic [7:0]      sum, sum_n;
`endif

   always_comb begin
      for (int i = 0; i < N_REQ; i++) src_byte[i] = req_data[8*i +: 8];
   end

   // Search starts just after the last completed grant, so a source is only re-granted when nobody else waits.
   always_comb begin
      arb_hit = 1'b0;
      arb_id  = '0;
      arb_idx = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         arb_idx = {1'b0, rr_ptr} + (GW+1)'(k);
         if (arb_idx >= NREQ_W) arb_idx = arb_idx - NREQ_W;
         if (!arb_hit && req_valid[arb_idx[GW-1:0]]) begin
            arb_hit = 1'b1;
            arb_id  = arb_idx[GW-1:0];
         end
      end
   end

   always_comb begin
      state_n   = state;
      tx_din_n  = tx_din;
      last_n    = last_f;
      grant_n   = grant_id;
      rr_n      = rr_ptr;
      gap_n     = gap_cnt;
      start_n   = 1'b0;
      done_n    = 1'b0;
      abort_n   = 1'b0;
      req_ready = '0;
`ifdef UART_TX_ARB_CHKSUM_EN
      sum_n     = sum;
`endif
      case (state)
         S_IDLE: begin
            gap_n = '0;
`ifdef UART_TX_ARB_CHKSUM_EN
            sum_n = '0;
`endif
            if (arb_hit) begin
               grant_n = arb_id;
               state_n = S_SEND;
            end
         end
         S_SEND: begin
            req_ready[grant_id] = 1'b1;
            if (req_valid[grant_id]) begin
               tx_din_n = src_byte[grant_id];
               last_n   = req_last[grant_id];
               start_n  = 1'b1;
               gap_n    = '0;
`ifdef UART_TX_ARB_CHKSUM_EN
               sum_n    = sum + src_byte[grant_id];
`endif
               state_n  = S_WAIT;
            end else if (GAP_TIMEOUT != 16'd0) begin
               if (gap_cnt == GAP_TIMEOUT - 16'd1) begin
                  abort_n = 1'b1;
                  rr_n    = grant_id;
                  state_n = S_IDLE;
               end else begin
                  gap_n = gap_cnt + 16'd1;
               end
            end
         end
         S_WAIT: begin
            if (tx_done_tick) begin
               if (!last_f) begin
                  state_n = S_SEND;
               end else begin
`ifdef UART_TX_ARB_CHKSUM_EN
                  state_n = S_CHK;
`else
                  done_n  = 1'b1;
                  rr_n    = grant_id;
                  state_n = S_IDLE;
`endif
               end
            end
         end
`ifdef UART_TX_ARB_CHKSUM_EN
         S_CHK: begin
            tx_din_n = ~sum + 8'd1;
            start_n  = 1'b1;
            state_n  = S_WAIT_CHK;
         end
         S_WAIT_CHK: begin
            if (tx_done_tick) begin
               done_n  = 1'b1;
               rr_n    = grant_id;
               state_n = S_IDLE;
            end
         end
`endif
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         tx_din    <= '0;
         last_f    <= 1'b0;
         grant_id  <= '0;
         rr_ptr    <= RR_INIT;
         gap_cnt   <= '0;
         tx_start  <= 1'b0;
         pkt_done  <= 1'b0;
         err_abort <= 1'b0;
`ifdef UART_TX_ARB_CHKSUM_EN
         sum       <= '0;
`endif
      end else begin
         state     <= state_n;
         tx_din    <= tx_din_n;
         last_f    <= last_n;
         grant_id  <= grant_n;
         rr_ptr    <= rr_n;
         gap_cnt   <= gap_n;
         tx_start  <= start_n;
         pkt_done  <= done_n;
         err_abort <= abort_n;
`ifdef UART_TX_ARB_CHKSUM_EN
         sum       <= sum_n;
`endif
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-source byte queues, a uart_tx stand-in, table vectors plus corner sequences.
module tb_uart_tx_arbiter;
   localparam int N = 4;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req_valid, req_last, req_ready;
   logic [8*N-1:0] req_data;
   logic           tx_start, tx_done_tick, busy, pkt_done, err_abort;
   logic [7:0]     tx_din;
   logic [1:0]     grant_id;

   uart_tx_arbiter #(.N_REQ(N), .GAP_TIMEOUT(16'd10)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick),
      .busy(busy), .grant_id(grant_id), .pkt_done(pkt_done), .err_abort(err_abort));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

`ifdef UART_TX_ARB_CHKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   int checks = 0, errors = 0;
   logic [8:0] q0[$], q1[$], q2[$], q3[$];
   logic [9:0] txlog[$], expq[$];
   int pkt_cnt = 0, abort_cnt = 0, cyc = 0, uart_cnt = 0;
   int dbl_start = 0, din_unstable = 0, t_r3 = -1, t_abort = -1, t_v = -1, t_rd = -1, t_st = -1;
   logic outstanding = 1'b0, prev_r3 = 1'b0;
   logic [7:0] held = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input int s, input logic [7:0] d, input logic l);
      case (s)
         0: q0.push_back({l, d});
         1: q1.push_back({l, d});
         2: q2.push_back({l, d});
         default: q3.push_back({l, d});
      endcase
   endtask

   task automatic clear_q();
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
   endtask

   task automatic refresh();
      logic [8:0] h [N];
      for (int i = 0; i < N; i++) h[i] = '0;
      req_valid = '0;
      if (q0.size() > 0) begin h[0] = q0[0]; req_valid[0] = 1'b1; end
      if (q1.size() > 0) begin h[1] = q1[0]; req_valid[1] = 1'b1; end
      if (q2.size() > 0) begin h[2] = q2[0]; req_valid[2] = 1'b1; end
      if (q3.size() > 0) begin h[3] = q3[0]; req_valid[3] = 1'b1; end
      for (int i = 0; i < N; i++) begin
         req_data[8*i +: 8] = h[i][7:0];
         req_last[i]        = h[i][8];
      end
   endtask

   // Source driver: handshake judged on the values that will be present at the coming edge.
   initial begin
      logic [N-1:0] fire;
      req_valid = '0; req_data = '0; req_last = '0;
      forever begin
         @(negedge clk);
         fire = req_valid & req_ready;
         @(posedge clk); #1;
         if (fire[0] && q0.size() > 0) void'(q0.pop_front());
         if (fire[1] && q1.size() > 0) void'(q1.pop_front());
         if (fire[2] && q2.size() > 0) void'(q2.pop_front());
         if (fire[3] && q3.size() > 0) void'(q3.pop_front());
         refresh();
      end
   end

   // uart_tx stand-in (done 3 cycles after start) and observation of output pulses.
   initial begin
      tx_done_tick = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         tx_done_tick = 1'b0;
         if (rst) begin
            uart_cnt = 0;
            outstanding = 1'b0;
         end else begin
            if (uart_cnt > 0) begin
               uart_cnt--;
               if (uart_cnt == 0) begin tx_done_tick = 1'b1; outstanding = 1'b0; end
            end
            if (tx_start) begin
               if (outstanding) dbl_start++;
               outstanding = 1'b1;
               held = tx_din;
               uart_cnt = 3;
               txlog.push_back({grant_id, tx_din});
            end else if (outstanding && tx_din != held) begin
               din_unstable++;
            end
            if (pkt_done) pkt_cnt++;
            if (err_abort) begin abort_cnt++; t_abort = cyc; end
            if (req_ready[3] && !prev_r3) t_r3 = cyc;
            if (t_v < 0 && req_valid[0] && !busy) t_v = cyc;
            if (t_rd < 0 && req_ready[0]) t_rd = cyc;
            if (t_st < 0 && tx_start) t_st = cyc;
         end
         prev_r3 = req_ready[3];
      end
   end

   task automatic wait_pkts(input int target);
      for (int i = 0; i < 400 && pkt_cnt < target; i++) begin @(posedge clk); #2; end
   endtask

   task automatic check_log(input string nm);
      chk({nm, "_len"}, txlog.size(), expq.size());
      for (int i = 0; i < expq.size(); i++)
         if (i < txlog.size()) chk($sformatf("%s_%0d", nm, i), txlog[i], expq[i]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_q();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   typedef struct {
      int          src;
      int          nb;
      logic [31:0] bytes;
      int          exp_ntx;
      logic [7:0]  exp_ck;
   } vec_t;

   initial begin
      vec_t vt [5];
      int   base;
      vt[0] = '{0, 2, 32'h0000_A355, 2 + CK, 8'h08};
      vt[1] = '{2, 3, 32'h0005_2010, 3 + CK, 8'hCB};
      vt[2] = '{1, 1, 32'h0000_00FF, 1 + CK, 8'h01};
      vt[3] = '{3, 2, 32'h0000_8080, 2 + CK, 8'h00};
      vt[4] = '{1, 4, 32'h0403_0201, 4 + CK, 8'hF6};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_din", tx_din, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pkt_done", pkt_done, 0);
      chk("rst_err_abort", err_abort, 0);
      rst = 1'b0;

      for (int v = 0; v < 5; v++) begin
         txlog.delete();
         base = pkt_cnt + 1;
         for (int j = 0; j < vt[v].nb; j++)
            push(vt[v].src, vt[v].bytes[8*j +: 8], j == vt[v].nb - 1);
         wait_pkts(base);
         chk($sformatf("vec%0d_done", v), pkt_cnt, base);
         chk($sformatf("vec%0d_busy", v), busy, 0);
         chk($sformatf("vec%0d_ntx", v), txlog.size(), vt[v].exp_ntx);
         for (int j = 0; j < vt[v].exp_ntx; j++) begin
            if (j < txlog.size()) begin
               chk($sformatf("vec%0d_gnt%0d", v, j), txlog[j][9:8], vt[v].src);
               chk($sformatf("vec%0d_byte%0d", v, j), txlog[j][7:0],
                   (j < vt[v].nb) ? vt[v].bytes[8*j +: 8] : vt[v].exp_ck);
            end
         end
      end
      chk("lat_ready", t_rd - t_v, 1);
      chk("lat_start", t_st - t_v, 2);

      // Round robin between two, then three continuously requesting sources.
      do_reset();
      txlog.delete(); base = pkt_cnt + 4;
      push(0, 8'hA0, 1); push(0, 8'hA1, 1); push(2, 8'hC0, 1); push(2, 8'hC1, 1);
      wait_pkts(base);
`ifdef UART_TX_ARB_CHKSUM_EN
      expq = '{10'h0A0, 10'h060, 10'h2C0, 10'h240, 10'h0A1, 10'h05F, 10'h2C1, 10'h23F};
`else
      expq = '{10'h0A0, 10'h2C0, 10'h0A1, 10'h2C1};
`endif
      check_log("rr2");
      txlog.delete(); base = pkt_cnt + 3;
      push(0, 8'hD0, 1); push(1, 8'hB0, 1); push(2, 8'hE0, 1);
      wait_pkts(base);
`ifdef UART_TX_ARB_CHKSUM_EN
      expq = '{10'h0D0, 10'h030, 10'h1B0, 10'h150, 10'h2E0, 10'h220};
`else
      expq = '{10'h0D0, 10'h1B0, 10'h2E0};
`endif
      check_log("rr3");

      // Lock: src0 requests while src1's packet is in flight.
      txlog.delete(); base = pkt_cnt + 2;
      push(1, 8'h31, 0); push(1, 8'h32, 0); push(1, 8'h33, 1);
      repeat (3) @(posedge clk);
      #2;
      chk("lock_grant", {busy, grant_id}, 3'b101);
      push(0, 8'h0F, 1);
      wait_pkts(base);
`ifdef UART_TX_ARB_CHKSUM_EN
      expq = '{10'h131, 10'h132, 10'h133, 10'h16A, 10'h00F, 10'h0F1};
`else
      expq = '{10'h131, 10'h132, 10'h133, 10'h00F};
`endif
      check_log("lock");

      // Gap timeout: src3 stalls after a non-last byte.
      txlog.delete(); base = abort_cnt + 1;
      begin
         int pk;
         pk = pkt_cnt;
         push(3, 8'h77, 0);
         for (int i = 0; i < 100 && abort_cnt < base; i++) begin @(posedge clk); #2; end
         chk("abort_seen", abort_cnt, base);
         chk("abort_delay", t_abort - t_r3, 10);
         repeat (6) @(posedge clk);
         #2;
         chk("abort_ntx", txlog.size(), 1);
         chk("abort_byte", txlog[0], 10'h377);
         chk("abort_no_done", pkt_cnt, pk);
         chk("abort_busy", busy, 0);
      end
      txlog.delete(); base = pkt_cnt + 2;
      push(1, 8'h45, 1); push(0, 8'h44, 1);
      wait_pkts(base);
`ifdef UART_TX_ARB_CHKSUM_EN
      expq = '{10'h044, 10'h0BC, 10'h145, 10'h1BB};
`else
      expq = '{10'h044, 10'h145};
`endif
      check_log("after_abort");

      // Reset while waiting on the serializer.
      txlog.delete();
      push(2, 8'h61, 0); push(2, 8'h62, 1);
      for (int i = 0; i < 50 && txlog.size() == 0; i++) begin @(posedge clk); #2; end
      chk("midrst_started", txlog.size(), 1);
      base = pkt_cnt;
      rst = 1'b1;
      clear_q();
      @(posedge clk);
      #2;
      chk("midrst_tx_start", tx_start, 0);
      chk("midrst_tx_din", tx_din, 0);
      chk("midrst_req_ready", req_ready, 0);
      chk("midrst_grant", grant_id, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_pulses", {pkt_done, err_abort}, 0);
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      chk("midrst_no_done", pkt_cnt, base);
      txlog.delete(); base = pkt_cnt + 2;
      push(2, 8'h71, 1); push(0, 8'h70, 1);
      wait_pkts(base);
`ifdef UART_TX_ARB_CHKSUM_EN
      expq = '{10'h070, 10'h090, 10'h271, 10'h28F};
`else
      expq = '{10'h070, 10'h271};
`endif
      check_log("post_rst");

      chk("double_start", dbl_start, 0);
      chk("din_stable", din_unstable, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
